// File: rtl/hv_dac_pkg.sv
// HV bias DAC controller shared types.
// Scheduler states, CTRL bit indices and the serial frame builder.
package hv_dac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_LDAC
  } state_e;

  localparam int CTRL_DEFER   = 0;
  localparam int CTRL_LOAD    = 1;
  localparam int CTRL_REFRESH = 2;
  localparam int CTRL_BUSY    = 3;

  // {1'b0, local_ch, value}; the leading 0 falls out of lch < CH_PER_DAC
  function automatic logic [31:0] build_frame(
    input int          dac_bits,
    input logic [31:0] lch,
    input logic [31:0] val
  );
    logic [31:0] mask;
    mask = (32'd1 << dac_bits) - 32'd1;
    return (lch << dac_bits) | (val & mask);
  endfunction

endpackage

// File: rtl/hv_dac_spi_ctrl_if.sv
// Slow-command register bus between DTC decoder and HV DAC controller.
// master: decoder (strobes, address, data); slave: controller (read data).
interface hv_dac_spi_ctrl_if;
  logic        cmd_wr;
  logic        cmd_rd;
  logic [30:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output cmd_wr, cmd_rd, cmd_addr, cmd_wdata,
    input  rd_data, rd_valid
  );

  modport slave (
    input  cmd_wr, cmd_rd, cmd_addr, cmd_wdata,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/hv_dac_spi_shift.sv
// Frame serialiser: start loads frame; sclk idles high, din MSB first.
// Ports: dtc_clk, rst_n, start, frame in; active, sclk, din, done out.
module hv_dac_spi_shift #(
  parameter int FRAME_BITS = 16,
  parameter int SCLK_DIV   = 4
) (
  input  logic                  dtc_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  active,
  output logic                  sclk,
  output logic                  din,
  output logic                  done
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);

  logic [FRAME_BITS-1:0] sh;
  logic [DW-1:0]         cnt;
  logic [BW-1:0]         bits;
  logic                  ph_end;
  logic                  last;

  assign ph_end = (cnt == DW'(SCLK_DIV - 1));
  assign last   = (bits == BW'(FRAME_BITS));
  assign din    = active & sh[FRAME_BITS-1];
  // frame ends after the high phase that follows the last rising edge
  assign done   = active & ph_end & sclk & last;

  always_ff @(posedge dtc_clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      sclk   <= 1'b1;
      sh     <= '0;
      cnt    <= '0;
      bits   <= '0;
    end else if (start && !active) begin
      active <= 1'b1;
      sclk   <= 1'b1;
      sh     <= frame;
      cnt    <= '0;
      bits   <= '0;
    end else if (active) begin
      if (ph_end) begin
        cnt <= '0;
        if (sclk) begin
          if (last) active <= 1'b0;
          else      sclk   <= 1'b0;
        end else begin
          sclk <= 1'b1;
          bits <= bits + 1'b1;
          sh   <= {sh[FRAME_BITS-2:0], 1'b0};
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hv_dac_spi_ctrl.sv
// N-chip x M-channel HV bias DAC controller: setpoint file, dirty scan,
// shared serial bus with per-chip sync_b, LDAC control. Ports: clk/rst, bus, pins.
module hv_dac_spi_ctrl
  import hv_dac_pkg::*;
#(
  parameter int NUM_DACS   = 4,
  parameter int CH_PER_DAC = 8,
  parameter int DAC_BITS   = 12,
  parameter int BASE_ADDR  = 'h60,
  parameter int CTRL_ADDR  = 'h71,
  parameter int SCLK_DIV   = 4,
  parameter int SYNC_GAP   = 4,
  parameter int LDAC_CYC   = 4
) (
  input  logic                dtc_clk,
  input  logic                rst_n,
  hv_dac_spi_ctrl_if.slave    bus,
  output logic                busy,
  output logic                hv_dac_sclk,
  output logic                hv_dac_din,
  output logic [NUM_DACS-1:0] hv_dac_sync_b,
  output logic                hv_dac_ldac_b
);

  localparam int NUM_CH     = NUM_DACS * CH_PER_DAC;
  localparam int CH_AW      = $clog2(CH_PER_DAC);
  localparam int FRAME_BITS = 1 + CH_AW + DAC_BITS;
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e state, state_n;

  logic [DAC_BITS-1:0]   sp [NUM_CH];
  logic [NUM_CH-1:0]     dirty, dirty_n;
  logic [CHW-1:0]        last_ch, cur_ch, pick_ch, wch;
  logic [30:0]           off;
  logic [15:0]           cnt;
  logic [31:0]           rd_mux;
  logic [FRAME_BITS-1:0] frame;
  logic found, defer, pend, start, ldac_go;
  logic ctrl_hit, ch_hit, ctrl_wr, ch_wr, load_wr, refr_wr;
  logic sh_active, sh_done;
  int   idx;

  // CTRL decodes first so it wins where it aliases a channel slot
  assign off      = bus.cmd_addr - 31'(BASE_ADDR);
  assign ctrl_hit = (bus.cmd_addr == 31'(CTRL_ADDR));
  assign ch_hit   = !ctrl_hit
                  && (bus.cmd_addr >= 31'(BASE_ADDR))
                  && (off < 31'(NUM_CH));
  assign wch      = off[CHW-1:0];
  assign ctrl_wr  = bus.cmd_wr & ctrl_hit;
  assign ch_wr    = bus.cmd_wr & ch_hit;
  assign load_wr  = ctrl_wr & bus.cmd_wdata[CTRL_LOAD];
  assign refr_wr  = ctrl_wr & bus.cmd_wdata[CTRL_REFRESH];

  assign busy          = (state != S_IDLE) || (dirty != '0);
  assign hv_dac_ldac_b = (state != S_LDAC);

  // round-robin: first dirty channel after the last one sent
  always_comb begin
    found   = 1'b0;
    pick_ch = '0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(last_ch) + 1 + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && dirty[idx]) begin
        found   = 1'b1;
        pick_ch = CHW'(idx);
      end
    end
  end

  assign frame = FRAME_BITS'(build_frame(
    DAC_BITS, 32'(pick_ch[CH_AW-1:0]), 32'(sp[pick_ch])));

  // a write landing on the channel being picked re-arms its dirty bit
  always_comb begin
    dirty_n = dirty;
    if (start)   dirty_n[pick_ch] = 1'b0;
    if (refr_wr) dirty_n = '1;
    if (ch_wr)   dirty_n[wch] = 1'b1;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    ldac_go = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          start   = 1'b1;
          state_n = S_SETUP;
        end else if (pend) begin
          ldac_go = 1'b1;
          state_n = S_LDAC;
        end
      end
      S_SETUP: if (!hv_dac_sclk) state_n = S_SHIFT;
      S_SHIFT: if (sh_done) state_n = S_GAP;
      S_GAP: begin
        if (cnt == 16'(SYNC_GAP - 1)) begin
          if (!defer || (pend && dirty == '0)) begin
            ldac_go = 1'b1;
            state_n = S_LDAC;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_LDAC: if (cnt == 16'(LDAC_CYC - 1)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    if (bus.cmd_rd) begin
      if (ctrl_hit)    rd_mux = 32'({busy, 2'b00, defer});
      else if (ch_hit) rd_mux = 32'(sp[wch]);
    end
  end

  always_comb begin
    hv_dac_sync_b = '1;
    for (int k = 0; k < NUM_DACS; k++) begin
      if (sh_active && (int'(cur_ch) / CH_PER_DAC == k))
        hv_dac_sync_b[k] = 1'b0;
    end
  end

  always_ff @(posedge dtc_clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dirty        <= '0;
      last_ch      <= CHW'(NUM_CH - 1);
      cur_ch       <= '0;
      defer        <= 1'b0;
      pend         <= 1'b0;
      cnt          <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) sp[i] <= '0;
    end else begin
      state <= state_n;
      dirty <= dirty_n;
      cnt   <= (state_n != state) ? '0 : cnt + 16'd1;
      if (start) begin
        last_ch <= pick_ch;
        cur_ch  <= pick_ch;
      end
      if (ctrl_wr) defer <= bus.cmd_wdata[CTRL_DEFER];
      if (load_wr) pend <= 1'b1;
      else if (ldac_go && dirty == '0) pend <= 1'b0;
      if (ch_wr) sp[wch] <= bus.cmd_wdata[DAC_BITS-1:0];
      bus.rd_valid <= bus.cmd_rd;
      bus.rd_data  <= rd_mux;
    end
  end

  hv_dac_spi_shift #(
    .FRAME_BITS (FRAME_BITS),
    .SCLK_DIV   (SCLK_DIV)
  ) u_shift (
    .dtc_clk (dtc_clk),
    .rst_n   (rst_n),
    .start   (start),
    .frame   (frame),
    .active  (sh_active),
    .sclk    (hv_dac_sclk),
    .din     (hv_dac_din),
    .done    (sh_done)
  );

endmodule

// File: tb/tb_hv_dac_spi_ctrl.sv
// Bench for hv_dac_spi_ctrl at default parameters.
// Pin monitor decodes frames and LDAC pulses against an expectation queue.
module tb_hv_dac_spi_ctrl;

  logic       dtc_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       busy, sclk, din, ldac_b;
  logic [3:0] sync_b;

  always #5 dtc_clk = ~dtc_clk;

  hv_dac_spi_ctrl_if bus ();

  hv_dac_spi_ctrl dut (
    .dtc_clk       (dtc_clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .busy          (busy),
    .hv_dac_sclk   (sclk),
    .hv_dac_din    (din),
    .hv_dac_sync_b (sync_b),
    .hv_dac_ldac_b (ldac_b)
  );

  typedef struct {
    int          chip;
    logic [15:0] data;
  } frm_t;

  typedef struct {
    bit          do_wr;
    logic [30:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  frm_t        expq[$];
  vec_t        tbl[6];
  logic [11:0] mdl[32];
  int          last_ch = 31;
  int          checks  = 0;
  int          errors  = 0;
  int          ldac_pulses = 0;
  int          ldac_w = 0;
  int          ldac_last = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_frame(input int ch);
    frm_t f;
    f.chip = ch / 8;
    f.data = 16'((ch % 8) << 12) | 16'(mdl[ch]);
    expq.push_back(f);
    last_ch = ch;
  endtask

  task automatic wr(input logic [30:0] a, input logic [31:0] d);
    @(negedge dtc_clk);
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge dtc_clk);
    bus.cmd_wr    = 1'b0;
  endtask

  task automatic rd(input logic [30:0] a, input logic [31:0] e,
                    input string nm);
    @(negedge dtc_clk);
    bus.cmd_rd   = 1'b1;
    bus.cmd_addr = a;
    @(negedge dtc_clk);
    bus.cmd_rd   = 1'b0;
    chk({nm, "_vld"}, 32'(bus.rd_valid), 32'd1);
    chk(nm, bus.rd_data, e);
  endtask

  task automatic wait_idle(input int max, input string nm);
    int idle;
    idle = 0;
    checks++;
    for (int i = 0; i < max; i++) begin
      @(negedge dtc_clk);
      if (!busy && ldac_b) idle++;
      else idle = 0;
      if (idle >= 3) return;
    end
    errors++;
    $display("FAIL %s: still busy after %0d cycles, expected idle", nm, max);
  endtask

  // pin monitor: frames sampled on sclk falling edges while a sync_b is low
  logic        prev_sclk = 1'b1;
  bit          capt = 0;
  int          cap_chip = 0;
  int          nbits = 0;
  logic [31:0] cap = '0;

  always @(negedge dtc_clk) begin
    int lows, lidx;
    frm_t f;
    if (!rst_n) begin
      capt      = 0;
      prev_sclk = 1'b1;
      ldac_w    = 0;
    end else begin
      lows = 0;
      lidx = 0;
      for (int k = 0; k < 4; k++)
        if (!sync_b[k]) begin lows++; lidx = k; end
      if (lows > 1) begin
        errors++;
        $display("FAIL sync_onehot: got %b expected at most one low", sync_b);
      end
      if (lows == 0 && !sclk) begin
        errors++;
        $display("FAIL sclk_idle: got sclk=0 expected 1 with no sync_b low");
      end
      if (lows == 1) begin
        if (!capt) begin
          capt = 1; cap = '0; nbits = 0; cap_chip = lidx;
        end
        if (prev_sclk && !sclk) begin
          cap = {cap[30:0], din};
          nbits++;
        end
      end else if (capt) begin
        capt = 0;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexp: got chip %0d data %h expected none",
                   cap_chip, cap[15:0]);
        end else begin
          f = expq.pop_front();
          chk("frame_chip", 32'(cap_chip), 32'(f.chip));
          chk("frame_bits", 32'(nbits), 32'd16);
          chk("frame_data", cap, 32'(f.data));
        end
      end
      prev_sclk = sclk;
      if (!ldac_b) ldac_w++;
      else if (ldac_w > 0) begin
        ldac_pulses++;
        ldac_last = ldac_w;
        ldac_w = 0;
      end
    end
  end

  initial begin
    int p0;
    bus.cmd_wr = 0; bus.cmd_rd = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    tbl[0] = '{1'b1, 31'h80, 32'h0000_0123, 32'h0};
    tbl[1] = '{1'b0, 31'h61, 32'h0,         32'h77};
    tbl[2] = '{1'b0, 31'h6A, 32'h0,         32'h99};
    tbl[3] = '{1'b1, 31'h7E, 32'hFFFF_F123, 32'h123};
    tbl[4] = '{1'b0, 31'h71, 32'h0,         32'h9};
    tbl[5] = '{1'b0, 31'h5F, 32'h0,         32'h0};

    // reset state
    repeat (5) @(negedge dtc_clk);
    chk("rst_sync", 32'(sync_b), 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_ldac", 32'(ldac_b), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdv", 32'(bus.rd_valid), 32'd0);
    chk("rst_rdd", bus.rd_data, 32'd0);
    rst_n = 1'b1;
    rd(31'h71, 32'h0, "ctrl_rst");
    rd(31'h60, 32'h0, "ch0_rst");

    // single frame, immediate LDAC
    p0 = ldac_pulses;
    wr(31'h60, 32'h033); mdl[0] = 12'h033; exp_frame(0);
    wait_idle(400, "t2_idle");
    chk("t2_q", 32'(expq.size()), 32'd0);
    chk("t2_ldac_n", 32'(ldac_pulses - p0), 32'd1);
    chk("t2_ldac_w", 32'(ldac_last), 32'd4);

    // deferred LDAC, then load_now
    p0 = ldac_pulses;
    wr(31'h71, 32'h1);
    wr(31'h61, 32'h077); mdl[1]  = 12'h077; exp_frame(1);
    wr(31'h6A, 32'h099); mdl[10] = 12'h099; exp_frame(10);
    wait_idle(800, "t3_idle");
    chk("t3_q", 32'(expq.size()), 32'd0);
    chk("t3_noldac", 32'(ldac_pulses - p0), 32'd0);
    wr(31'h71, 32'h3);
    wait_idle(100, "t3_load");
    chk("t3_ldac_n", 32'(ldac_pulses - p0), 32'd1);
    chk("t3_ldac_w", 32'(ldac_last), 32'd4);
    rd(31'h71, 32'h1, "t3_ctrl");

    // rewrite of the channel being shifted
    wr(31'h62, 32'h099); mdl[2] = 12'h099; exp_frame(2);
    repeat (20) @(negedge dtc_clk);
    wr(31'h62, 32'h0AB); mdl[2] = 12'h0AB; exp_frame(2);
    wait_idle(800, "t4_idle");
    chk("t4_q", 32'(expq.size()), 32'd0);

    // register table: decode, data masking, CTRL busy bit
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].do_wr) begin
        wr(tbl[i].addr, tbl[i].wdata);
        if (tbl[i].addr >= 31'h60 && tbl[i].addr < 31'h80) begin
          mdl[int'(tbl[i].addr) - 'h60] = tbl[i].wdata[11:0];
          exp_frame(int'(tbl[i].addr) - 'h60);
        end
      end
      rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    wait_idle(800, "tbl_idle");
    chk("tbl_q", 32'(expq.size()), 32'd0);

    // same-cycle write and read return the old value
    @(negedge dtc_clk);
    bus.cmd_wr = 1'b1; bus.cmd_rd = 1'b1;
    bus.cmd_addr = 31'h61; bus.cmd_wdata = 32'h0AA;
    @(negedge dtc_clk);
    bus.cmd_wr = 1'b0; bus.cmd_rd = 1'b0;
    chk("wrrd_old", bus.rd_data, 32'h77);
    mdl[1] = 12'h0AA; exp_frame(1);
    rd(31'h61, 32'hAA, "wrrd_new");
    wait_idle(800, "wrrd_idle");

    // refresh_all: every channel, round-robin from the last sent
    p0 = ldac_pulses;
    wr(31'h71, 32'h5);
    begin
      int base;
      base = last_ch;
      for (int i = 1; i <= 32; i++) exp_frame((base + i) % 32);
    end
    wait_idle(6000, "t5_idle");
    chk("t5_q", 32'(expq.size()), 32'd0);
    chk("t5_noldac", 32'(ldac_pulses - p0), 32'd0);

    // reset in the middle of a frame
    p0 = ldac_pulses;
    wr(31'h60, 32'h055);
    repeat (30) @(negedge dtc_clk);
    chk("t6_inframe", 32'(sync_b), 32'hE);
    rst_n = 1'b0;
    @(negedge dtc_clk);
    chk("t6_sync", 32'(sync_b), 32'hF);
    chk("t6_sclk", 32'(sclk), 32'd1);
    chk("t6_ldac", 32'(ldac_b), 32'd1);
    expq.delete();
    repeat (3) @(negedge dtc_clk);
    rst_n = 1'b1;
    rd(31'h60, 32'h0, "t6_ch0");
    rd(31'h71, 32'h0, "t6_ctrl");
    repeat (200) @(negedge dtc_clk);
    chk("t6_noldac", 32'(ldac_pulses - p0), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
